// File: rtl/flash_read_arbiter.sv
// Two-port arbiter in front of the single flash read FSM: one read per grant.
// Optional WAIT watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_read_arbiter #(
    parameter int                ADDR_W         = 23,
    parameter logic [ADDR_W-1:0] MAX_ADDR       = 23'h7FFFF,
    parameter bit                ROUND_ROBIN    = 1'b1,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              flash_start,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_finish,
    input  logic [31:0]       flash_data,
    output logic              busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_COMPLETE = 3'd4;

    logic [2:0] state;
    logic       owner;
    logic       last_grant;
    logic       grant;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign busy = (state != S_IDLE);

    // A lone request always wins; contention goes by policy.
    always_comb begin
        grant = req1;
        if (req0 && req1) begin
            grant = ROUND_ROBIN ? ~last_grant : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            done0       <= 1'b0;
            done1       <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            flash_start <= 1'b0;
            flash_addr  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            flash_start <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner      <= grant;
                        flash_addr <= grant ? addr1 : addr0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (flash_addr > MAX_ADDR) begin
                        err   <= 1'b1;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= S_COMPLETE;
                    end else begin
                        flash_start <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef FLASH_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (flash_finish) begin
                        rdata <= flash_data;
                        err   <= 1'b0;
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= S_COMPLETE;
`ifdef FLASH_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err      <= 1'b1;
                        done0    <= ~owner;
                        done1    <= owner;
                        wait_cnt <= '0;
                        state    <= S_COMPLETE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_COMPLETE: begin
                    last_grant <= owner;
                    err        <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: round-robin and fixed-priority instances
// driven in parallel, each checked every cycle against a transaction model.
module tb_flash_read_arbiter;

    localparam int          TO   = 16;
    localparam logic [22:0] MAXA = 23'h7FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [22:0] addr0 = '0, addr1 = '0;

    logic        d0[2], d1[2], er[2], fs[2], bz[2], ff[2];
    logic [31:0] rd[2], fd[2];
    logic [22:0] fa[2];

    flash_read_arbiter #(
        .ADDR_W(23), .MAX_ADDR(MAXA), .ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(TO)
    ) u_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .done0(d0[0]), .done1(d1[0]), .err(er[0]), .rdata(rd[0]),
        .flash_start(fs[0]), .flash_addr(fa[0]),
        .flash_finish(ff[0]), .flash_data(fd[0]), .busy(bz[0])
    );

    flash_read_arbiter #(
        .ADDR_W(23), .MAX_ADDR(MAXA), .ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(TO)
    ) u_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .done0(d0[1]), .done1(d1[1]), .err(er[1]), .rdata(rd[1]),
        .flash_start(fs[1]), .flash_addr(fa[1]),
        .flash_finish(ff[1]), .flash_data(fd[1]), .busy(bz[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, i, act, exp);
        end
    endtask

    // Transaction model: one read in flight, timed from its grant.
    bit          m_act[2], m_cmp[2], m_wait[2], m_err[2], m_fs[2];
    bit          m_own[2], m_last[2];
    int          m_t[2], m_wc[2];
    logic [31:0] m_rd[2];
    logic [22:0] m_fa[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] = 0; m_cmp[i] = 0; m_wait[i] = 0; m_err[i] = 0;
                m_fs[i] = 0; m_own[i] = 0; m_last[i] = 1;
                m_t[i] = 0; m_wc[i] = 0; m_rd[i] = '0; m_fa[i] = '0;
            end else if (!m_act[i]) begin
                if (req0 || req1) begin
                    if (req0 && req1) m_own[i] = (i == 0) ? !m_last[i] : 1'b0;
                    else m_own[i] = req1;
                    m_fa[i]  = m_own[i] ? addr1 : addr0;
                    m_act[i] = 1;
                    m_t[i]   = 0;
                end
            end else if (m_cmp[i]) begin
                m_cmp[i]  = 0;
                m_err[i]  = 0;
                m_act[i]  = 0;
                m_last[i] = m_own[i];
            end else if (m_wait[i]) begin
                if (ff[i]) begin
                    m_rd[i] = fd[i]; m_err[i] = 0; m_cmp[i] = 1; m_wait[i] = 0;
                end
`ifdef FLASH_ARB_TIMEOUT_EN
                else if (m_wc[i] == TO - 1) begin
                    m_err[i] = 1; m_cmp[i] = 1; m_wait[i] = 0; m_wc[i] = 0;
                end else begin
                    m_wc[i]++;
                end
`endif
            end else begin
                m_t[i]++;
                if (m_t[i] == 1) begin
                    if (m_fa[i] > MAXA) begin
                        m_err[i] = 1; m_cmp[i] = 1;
                    end else begin
                        m_fs[i] = 1;
                    end
                end else begin
                    m_fs[i] = 0; m_wait[i] = 1; m_wc[i] = 0;
                end
            end
        end
    end

    int glog[2][$];
    int nstart[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("done0", i, 32'(d0[i]), 32'(m_cmp[i] && !m_own[i]));
            chk("done1", i, 32'(d1[i]), 32'(m_cmp[i] && m_own[i]));
            chk("err", i, 32'(er[i]), 32'(m_cmp[i] && m_err[i]));
            chk("rdata", i, rd[i], m_rd[i]);
            chk("flash_start", i, 32'(fs[i]), 32'(m_fs[i]));
            chk("flash_addr", i, 32'(fa[i]), 32'(m_fa[i]));
            chk("busy", i, 32'(bz[i]), 32'(m_act[i]));
            if (d0[i] === 1'b1) glog[i].push_back(0);
            if (d1[i] === 1'b1) glog[i].push_back(1);
            if (fs[i] === 1'b1) nstart[i]++;
        end
    end

    // Flash FSM stand-in: auto reply resp_delay cycles after a start,
    // or a one-shot manual finish pulse.
    bit          auto_on = 1;
    int          resp_delay = 2;
    logic [31:0] resp_data = '0;
    bit          man_fin = 0;
    logic [31:0] man_data = '0;
    int          cnt[2];

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            ff[i] = 1'b0;
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    ff[i] = 1'b1;
                    fd[i] = resp_data;
                end
            end
            if (auto_on && fs[i] === 1'b1) cnt[i] = resp_delay;
            if (man_fin) begin
                ff[i] = 1'b1;
                fd[i] = man_data;
            end
        end
        man_fin = 0;
    endtask

    function automatic bit seen(input int kind);
        case (kind)
            0:       return d0[0] === 1'b1;
            1:       return d1[0] === 1'b1;
            default: return fs[0] === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int kind, input int budget);
        int n = 0;
        while (!seen(kind) && n < budget) begin
            step();
            n++;
        end
        if (!seen(kind)) begin
            tests++;
            fails++;
            $display("FAIL %s: no event within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s;
        int exp_rr[4];
        exp_rr = '{0, 1, 0, 1};
        for (int i = 0; i < 2; i++) begin
            ff[i] = 1'b0; fd[i] = '0; cnt[i] = 0; nstart[i] = 0;
        end
        repeat (3) step();
        chk("reset_rdata", 0, rd[0], 32'h0);
        chk("reset_busy", 0, 32'(bz[0]), 32'h0);
        chk("reset_done", 0, 32'(d0[0] | d1[0]), 32'h0);
        rst = 1'b0;
        step();

        // contention, both requests held
        addr0 = 23'd100; addr1 = 23'd200; req0 = 1; req1 = 1;
        k = 0;
        for (int n = 0; n < 100 && k < 4; n++) begin
            step();
            if (d0[0] === 1'b1 || d1[0] === 1'b1) k++;
        end
        req0 = 0; req1 = 0;
        repeat (4) step();
        chk("rr_count", 0, 32'(glog[0].size()), 32'd4);
        chk("fp_count", 1, 32'(glog[1].size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < glog[0].size()) chk("rr_order", 0, 32'(glog[0][j]), 32'(exp_rr[j]));
            if (j < glog[1].size()) chk("fp_order", 1, 32'(glog[1][j]), 32'd0);
        end

        // single read
        resp_delay = 5; resp_data = 32'hA5A5_1234;
        s = nstart[0];
        addr0 = 23'h00010; req0 = 1;
        wait_for("single_done", 0, 40);
        chk("single_addr", 0, 32'(fa[0]), 32'h10);
        chk("single_rdata", 0, rd[0], 32'hA5A5_1234);
        chk("single_err", 0, 32'(er[0]), 32'h0);
        req0 = 0;
        repeat (2) step();
        chk("single_starts", 0, 32'(nstart[0] - s), 32'd1);

        // out of range on port 1
        s = nstart[0];
        addr1 = 23'h080000; req1 = 1;
        wait_for("oor_done", 1, 20);
        chk("oor_err", 0, 32'(er[0]), 32'h1);
        chk("oor_rdata", 0, rd[0], 32'hA5A5_1234);
        req1 = 0;
        repeat (2) step();
        chk("oor_starts", 0, 32'(nstart[0] - s), 32'd0);

        // highest legal address, request dropped mid-read
        resp_delay = 6; resp_data = 32'h0BAD_F00D;
        addr0 = 23'h7FFFF; req0 = 1;
        wait_for("drop_start", 2, 20);
        repeat (2) step();
        req0 = 0;
        wait_for("drop_done", 0, 20);
        chk("drop_rdata", 0, rd[0], 32'h0BAD_F00D);
        chk("drop_err", 0, 32'(er[0]), 32'h0);
        repeat (2) step();
        chk("drop_idle", 0, 32'(bz[0]), 32'h0);

        // finish while idle is ignored
        man_data = 32'hDEAD_BEEF; man_fin = 1;
        repeat (2) step();
        chk("idle_finish", 0, rd[0], 32'h0BAD_F00D);

        // reset while waiting, then a stale finish
        auto_on = 0;
        addr0 = 23'h00020; req0 = 1;
        wait_for("rst_start", 2, 20);
        repeat (2) step();
        rst = 1; req0 = 0;
        step();
        man_data = 32'h1111_2222; man_fin = 1;
        repeat (2) step();
        rst = 0;
        man_fin = 1;
        repeat (3) step();
        chk("rst_mid_rdata", 0, rd[0], 32'h0);
        chk("rst_mid_busy", 0, 32'(bz[0]), 32'h0);
        chk("rst_mid_addr", 0, 32'(fa[0]), 32'h0);

`ifdef FLASH_ARB_TIMEOUT_EN
        addr0 = 23'h00030; req0 = 1;
        wait_for("to_start", 2, 20);
        req0 = 0;
        k = 0;
        while (d0[0] !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("to_latency", 0, 32'(k), 32'd17);
        chk("to_err", 0, 32'(er[0]), 32'h1);
        chk("to_rdata", 0, rd[0], 32'h0);
        man_data = 32'h3333_4444; man_fin = 1;
        repeat (3) step();
        chk("to_late", 0, rd[0], 32'h0);
`endif

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single flash read FSM (start/finish handshake) between two requesters.
- Port 0 is the audio address handler; port 1 is a secondary reader (e.g. LCD/metadata fetch).
- Latches the winning requester's address, launches one flash read, captures the 32-bit word and returns it with a one-cycle done pulse to the owner.
- Sits between the requesters and the flash FSM, replacing the direct start/finish wiring.

Parameters:
- ADDR_W, 23, flash word address width.
- MAX_ADDR, 23'h7FFFF, highest legal word address.
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = port 0 always wins.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 read request, level; held until done0
- addr0  in  ADDR_W  port 0 word address
- req1  in  1  port 1 read request, level; held until done1
- addr1  in  ADDR_W  port 1 word address
- done0  out  1  one-cycle pulse: port 0 read complete, rdata valid
- done1  out  1  one-cycle pulse: port 1 read complete, rdata valid
- err  out  1  valid with a done pulse: address out of range, or timeout
- rdata  out  32  last returned flash word; held until next completion
- flash_start  out  1  one-cycle pulse that launches the flash FSM
- flash_addr  out  ADDR_W  address to flash FSM; stable from ISSUE until COMPLETE
- flash_finish  in  1  flash FSM completion, sampled in WAIT only
- flash_data  in  32  flash word, valid when flash_finish=1
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, done0=done1=0, err=0, rdata=0, flash_start=0, flash_addr=0, busy=0, owner=0, last_grant=1 (so port 0 wins the first contention). Reset asserted mid-read abandons the read; a later flash_finish is ignored.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise grant per policy, latch owner and the owner's address into flash_addr, and go to CHECK.
  - ROUND_ROBIN=1 with both requests high: grant the port opposite last_grant.
  - ROUND_ROBIN=0 with both requests high: grant port 0.
  - Single request: grant that port.
- CHECK:
  - If flash_addr > MAX_ADDR: set err=1, do not start flash, go to COMPLETE; rdata is unchanged.
  - Otherwise go to ISSUE.
- ISSUE: flash_start=1 for exactly this cycle, then go to WAIT.
- WAIT: on flash_finish=1, rdata<=flash_data, err<=0, go to COMPLETE. Otherwise stay in WAIT.
- COMPLETE: pulse done of the owner for one cycle, update last_grant=owner, go to IDLE.
- Latency: grant to flash_start is 2 cycles. flash_finish to done is 1 cycle. A back-to-back grant is possible on the cycle after done.
- A req dropped after grant does not abort the read; done is still pulsed.
- A req still high in the cycle after done is a new request.
- flash_finish in IDLE, CHECK, ISSUE or COMPLETE is ignored.
- done0 and done1 are never high together. err is 0 whenever both dones are 0.
- Addresses are passed unmodified; no wrap-around here. Wrap-around is the requester's job.

Optional Feature:
- Macro: FLASH_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles pass without flash_finish, go to COMPLETE with err=1 and rdata unchanged, and clear the counter.
  - A flash_finish arriving after the abort is ignored.
- Undefined: no counter; WAIT holds indefinitely.

Test Plan:
- Single read: req0=1, addr0=23'h00010; flash_finish 5 cycles after flash_start with flash_data=32'hA5A5_1234 -> flash_addr=23'h00010, one flash_start pulse, done0 pulse, rdata=32'hA5A5_1234, err=0.
- Contention, ROUND_ROBIN=1: req0=req1=1 held continuously -> grants in the order 0,1,0,1. With ROUND_ROBIN=0 -> grants 0,0,0.
- Out of range: req1=1, addr1=23'h080000 -> no flash_start, done1 pulse with err=1, rdata unchanged.
- Request drop: req0 deasserted in WAIT -> read completes, done0 still pulses, arbiter returns to IDLE.
- Reset mid-read: rst=1 in WAIT, then flash_finish pulses -> all outputs stay at reset values, no done pulse.
- FLASH_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: no flash_finish -> done pulse with err=1 exactly 16 cycles after WAIT entry; a late flash_finish is ignored.
